// File: rtl/i2c_slave_regfile.sv
// I2C slave front end serving a NUM_REGS x 8 register file with an auto-incrementing pointer.
// Optional glitch filter on SCL/SDA is enabled by defining I2C_SLAVE_FILTER_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILT_LEN   = 4,
  localparam int        REG_AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_data,
  output logic              busy,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ADDR = 4'd1, S_ADDR_ACK = 4'd2, S_PTR = 4'd3, S_PTR_ACK = 4'd4,
    S_WDATA = 4'd5, S_WDATA_ACK = 4'd6, S_RDATA = 4'd7, S_RDATA_ACK = 4'd8, S_WAIT = 4'd9
  } state_t;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  state_t            state_q, state_d;
  logic [1:0]        scl_sync, sda_sync;
  logic              scl_f, sda_f, scl_d, sda_d;
  logic              scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]        shift;
  logic [7:0]        byte_in;
  logic [2:0]        bit_cnt;
  logic              last_bit, ack_phase, rw_q, addr_match;
  logic              rx_state, ack_state;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic [FCW-1:0] scl_cnt, sda_cnt;

  // A filtered line only follows the raw line after FILT_LEN stable cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f <= 1'b1; sda_f <= 1'b1; scl_cnt <= '0; sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FCW'(FILT_LEN - 1)) begin scl_f <= scl_sync[1]; scl_cnt <= '0; end
      else scl_cnt <= scl_cnt + FCW'(1);
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FCW'(FILT_LEN - 1)) begin sda_f <= sda_sync[1]; sda_cnt <= '0; end
      else sda_cnt <= sda_cnt + FCW'(1);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  assign start_ev   = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev    = scl_f & scl_d & ~sda_d & sda_f;
  assign byte_in    = {shift[6:0], sda_f};
  assign last_bit   = (bit_cnt == 3'd7);
  assign addr_match = (shift[6:0] == SLAVE_ADDR);
  assign host_data  = regs[host_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_ev) state_d = S_IDLE;
    else if (start_ev) state_d = S_ADDR;
    else begin
      case (state_q)
        S_ADDR:      if (scl_rise && last_bit) state_d = addr_match ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK:  if (scl_fall && ack_phase) state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR:       if (scl_rise && last_bit) state_d = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall && ack_phase) state_d = S_WDATA;
        S_WDATA:     if (scl_rise && last_bit) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && ack_phase) state_d = S_WDATA;
        S_RDATA:     if (scl_fall && last_bit) state_d = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (scl_rise && sda_f) state_d = S_WAIT;
          else if (scl_fall)     state_d = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    rx_state  = (state_q == S_ADDR) || (state_q == S_PTR) || (state_q == S_WDATA);
    ack_state = (state_q == S_ADDR_ACK) || (state_q == S_PTR_ACK) || (state_q == S_WDATA_ACK);
  end

  // wr_strobe is a one-cycle pulse; wr_addr/wr_data are meaningful only while it is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_oe <= 1'b0; wr_strobe <= 1'b0; wr_addr <= '0; wr_data <= '0; busy <= 1'b0;
      shift <= '0; bit_cnt <= '0; ack_phase <= 1'b0; rw_q <= 1'b0; ptr <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_ev || stop_ev) begin
        sda_oe <= 1'b0; busy <= 1'b0; bit_cnt <= '0; ack_phase <= 1'b0;
      end else begin
        if (rx_state && scl_rise) begin
          shift   <= byte_in;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (ack_state && scl_fall) begin
          if (!ack_phase) begin
            sda_oe    <= 1'b1;
            ack_phase <= 1'b1;
          end else begin
            ack_phase <= 1'b0;
            bit_cnt   <= '0;
            // A read address phase hands straight over to the first data bit.
            if (state_q == S_ADDR_ACK && rw_q) begin
              shift  <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              sda_oe <= 1'b0;
            end
          end
        end
        case (state_q)
          S_ADDR: if (scl_rise && last_bit) begin
            rw_q <= sda_f;
            busy <= addr_match;
          end
          S_PTR: if (scl_rise && last_bit) ptr <= byte_in[REG_AW-1:0];
          S_WDATA: if (scl_rise && last_bit) begin
            regs[ptr] <= byte_in;
            wr_strobe <= 1'b1;
            wr_addr   <= ptr;
            wr_data   <= byte_in;
            ptr       <= ptr + REG_AW'(1);
          end
          S_RDATA: if (scl_fall) begin
            if (last_bit) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
            end else begin
              sda_oe  <= ~shift[6];
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              ptr <= ptr + REG_AW'(1);
              if (sda_f) busy <= 1'b0;
            end
            if (scl_fall) begin
              shift  <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, write-strobe scoreboard, directed transfers.
module tb_i2c_slave_regfile;

  localparam int Q = 8;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_RDATA = 4'd7, ST_WAIT = 4'd9;

  logic       clk, reset_n;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_oe, wr_strobe, busy;
  logic [3:0] wr_addr, host_addr, state;
  logic [7:0] wr_data, host_data;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic oe_seen, busy_seen;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .FILT_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_data(host_data), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (wr_strobe) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected actual=%0h_%0h expected=none", wr_addr, wr_data);
        end else begin
          check("wr_strobe", {20'd0, wr_addr, wr_data}, {20'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    seen = sda_bus; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(mack, dummy);
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    wait_clk(1);
    d = host_data;
  endtask

  initial begin
    logic       ack, dummy;
    logic [7:0] d;
    reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd3;
    oe_seen = 1'b0; busy_seen = 1'b0;
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, ST_IDLE);
    check("rst_wr_strobe", wr_strobe, 0);
    reset_n = 1'b1;
    wait_clk(4);
    host_read(4'd3, d); check("rst_reg3", d, 8'h00);

    // write S A0 03 5A C3 P
    exp_q.push_back({4'd3, 8'h5A});
    exp_q.push_back({4'd4, 8'hC3});
    i2c_start();
    write_byte(8'hA0, ack); check("w_ack_addr", ack, 0);
    check("w_busy", busy, 1);
    write_byte(8'h03, ack); check("w_ack_ptr", ack, 0);
    write_byte(8'h5A, ack); check("w_ack_d0", ack, 0);
    write_byte(8'hC3, ack); check("w_ack_d1", ack, 0);
    i2c_stop();
    check("w_busy_after_p", busy, 0);
    check("w_state_idle", state, ST_IDLE);
    host_read(4'd3, d); check("w_reg3", d, 8'h5A);
    host_read(4'd4, d); check("w_reg4", d, 8'hC3);

    // read S A0 03 Sr A1 rd(ACK) rd(NACK) P
    i2c_start();
    write_byte(8'hA0, ack); check("r_ack_addr", ack, 0);
    write_byte(8'h03, ack); check("r_ack_ptr", ack, 0);
    i2c_start();
    write_byte(8'hA1, ack); check("r_ack_raddr", ack, 0);
    read_byte(1'b0, d); check("r_byte0", d, 8'h5A);
    read_byte(1'b1, d); check("r_byte1", d, 8'hC3);
    check("r_oe_after_nack", sda_oe, 0);
    check("r_state_wait", state, ST_WAIT);
    check("r_busy_after_nack", busy, 0);
    i2c_stop();
    check("r_state_idle", state, ST_IDLE);

    // address miss: S A2 03 5A P
    wait_clk(2);
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check("m_nack_addr", ack, 1);
    write_byte(8'h03, ack); check("m_nack_ptr", ack, 1);
    write_byte(8'h5A, ack); check("m_nack_data", ack, 1);
    i2c_stop();
    check("m_oe_never", oe_seen, 0);
    check("m_busy_never", busy_seen, 0);
    host_read(4'd3, d); check("m_reg3_kept", d, 8'h5A);

    // pointer wrap: S A0 1F 11 22 P
    exp_q.push_back({4'hF, 8'h11});
    exp_q.push_back({4'h0, 8'h22});
    i2c_start();
    write_byte(8'hA0, ack); check("wr_ack_addr", ack, 0);
    write_byte(8'h1F, ack); check("wr_ack_ptr", ack, 0);
    write_byte(8'h11, ack); check("wr_ack_d0", ack, 0);
    write_byte(8'h22, ack); check("wr_ack_d1", ack, 0);
    i2c_stop();
    host_read(4'hF, d); check("wr_reg15", d, 8'h11);
    host_read(4'h0, d); check("wr_reg0", d, 8'h22);

    // abort: S A0 05, four data bits, P
    i2c_start();
    write_byte(8'hA0, ack); check("a_ack_addr", ack, 0);
    write_byte(8'h05, ack); check("a_ack_ptr", ack, 0);
    send_bit(1'b1, dummy); send_bit(1'b0, dummy);
    send_bit(1'b1, dummy); send_bit(1'b0, dummy);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(4);
    check("a_idle_after_p", state, ST_IDLE);
    wait_clk(Q);
    host_read(4'd5, d); check("a_reg5_kept", d, 8'h00);

    // reset while the slave drives a read bit (regs[5]=00, every bit pulls low)
    i2c_start();
    write_byte(8'hA1, ack); check("x_ack_raddr", ack, 0);
    check("x_state_rdata", state, ST_RDATA);
    check("x_oe_driving", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check("x_oe_released", sda_oe, 0);
    check("x_state_reset", state, ST_IDLE);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(2);
    host_read(4'd3, d); check("x_reg3_cleared", d, 8'h00);
    i2c_stop();
    wait_clk(4);

    check("wr_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
